// File: rtl/uart_boot_loader_if.sv
// ---------------------------------------------------------------------------
// uart_boot_loader_if
//
// Groups the UART RX handshake and the RAM write port used by the boot loader.
//
// Signals:
//   rx_valid   UART RX holds an unread byte          (RX    -> loader)
//   rx_rdata   UART RX byte                          (RX    -> loader)
//   rx_re      consume the RX byte this cycle        (loader -> RX)
//   ram_we     one-cycle RAM word-write strobe       (loader -> RAM)
//   ram_addr   RAM byte address, word aligned        (loader -> RAM)
//   ram_wdata  RAM write data                        (loader -> RAM)
//
// Modports:
//   master  the loader side (drives rx_re and the RAM port)
//   slave   the environment side (UART RX model plus RAM)
// ---------------------------------------------------------------------------
interface uart_boot_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_rdata;
    logic        rx_re;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;

    modport master (
        input  rx_valid,
        input  rx_rdata,
        output rx_re,
        output ram_we,
        output ram_addr,
        output ram_wdata
    );

    modport slave (
        output rx_valid,
        output rx_rdata,
        input  rx_re,
        input  ram_we,
        input  ram_addr,
        input  ram_wdata
    );
endinterface

// File: rtl/uart_boot_loader.sv
// ---------------------------------------------------------------------------
// uart_boot_loader
//
// Boot-time program loader sitting between the UART receiver and on-chip RAM.
// The core is held in reset while a length-prefixed image arrives on the RX
// byte stream. The first four bytes give the image length L in words
// (little-endian); the following 4*L bytes are packed little-endian into
// 32-bit words and written to consecutive RAM word addresses starting at
// BASE_ADDR. Once the last word has been written the core reset is released.
// A length of zero releases the core at once; a length above MAX_WORDS aborts
// the load, after which RX bytes are drained and discarded.
//
// Optional feature (macro BOOT_CHECKSUM_EN):
//   A running XOR of every byte taken during the length and data phases is
//   kept. After the image, one more byte is taken and compared against the
//   XOR: a match releases the core, a mismatch aborts the load.
//   With the macro undefined there is no checksum phase and no XOR register.
//
// Parameters:
//   BASE_ADDR  RAM byte address of word 0 of the image
//   MAX_WORDS  largest accepted image length in words
//   CNT_W      word counter width, 2**CNT_W must exceed MAX_WORDS
//
// Ports:
//   clk_i        system clock
//   rst_ni       synchronous active-low reset
//   bus          uart_boot_loader_if.master: RX handshake and RAM write port
//   core_rst_no  active-low core reset, 0 = core held in reset
//   busy_o       loader is still taking the image
//   done_o       image loaded, core released
//   err_o        load aborted
//   words_o      number of words written so far
// ---------------------------------------------------------------------------
module uart_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    uart_boot_loader_if.master bus,
    output logic               core_rst_no,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [CNT_W-1:0]   words_o
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    localparam logic [2:0] ST_LEN  = 3'd0;
    localparam logic [2:0] ST_DATA = 3'd1;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;
`ifdef BOOT_CHECKSUM_EN
    localparam logic [2:0] ST_CSUM = 3'd2;
    // The image is followed by a checksum byte before the core is released.
    localparam logic [2:0] ST_FIN  = ST_CSUM;
`else
    localparam logic [2:0] ST_FIN  = ST_DONE;
`endif

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [2:0]       state_q,     state_d;
    logic [1:0]       byte_idx_q,  byte_idx_d;
    logic [23:0]      shift_q,     shift_d;      // lanes 0..2; lane 3 comes straight from RX
    logic [CNT_W-1:0] len_q,       len_d;
    logic [CNT_W-1:0] word_cnt_q,  word_cnt_d;
    logic             ram_we_q,    ram_we_d;
    logic [31:0]      ram_addr_q,  ram_addr_d;
    logic [31:0]      ram_wdata_q, ram_wdata_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]       csum_q,      csum_d;
`endif

    // -----------------------------------------------------------------------
    // Byte acceptance
    // -----------------------------------------------------------------------
    logic        accepting;
    logic        take;
    logic [31:0] word_asm;
    logic [31:0] word_cnt_ext;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        accepting = 1'b0;
        case (state_q)
            ST_LEN, ST_DATA: accepting = 1'b1;
`ifdef BOOT_CHECKSUM_EN
            ST_CSUM:         accepting = 1'b1;
`endif
            // Drain bytes after an abort so the UART does not overrun.
            ST_ERR:          accepting = 1'b1;
            // In DONE the bytes belong to the core's own UART driver.
            default:         accepting = 1'b0;
        endcase
    end

    assign take         = bus.rx_valid & accepting;
    assign word_asm     = {bus.rx_rdata, shift_q};
    assign word_cnt_ext = 32'(word_cnt_q);
    assign cnt_inc      = word_cnt_q + CNT_W'(1);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        shift_d     = shift_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        if (take) begin
            case (state_q)
                ST_LEN, ST_DATA: begin
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
                    csum_d = csum_q ^ bus.rx_rdata;
`endif
                    case (byte_idx_q)
                        2'd0: shift_d[7:0]   = bus.rx_rdata;
                        2'd1: shift_d[15:8]  = bus.rx_rdata;
                        2'd2: shift_d[23:16] = bus.rx_rdata;
                        default: begin
                            if (state_q == ST_LEN) begin
                                if (word_asm == 32'd0) begin
                                    state_d = ST_FIN;
                                end else if (word_asm > MAX_WORDS) begin
                                    state_d = ST_ERR;
                                end else begin
                                    state_d = ST_DATA;
                                    len_d   = word_asm[CNT_W-1:0];
                                end
                            end else begin
                                // Word complete: strobe it out next cycle. The
                                // counter moves with the strobe, and the image
                                // end is detected on the same edge so no stray
                                // byte can slip into DATA after the last word.
                                ram_we_d    = 1'b1;
                                ram_wdata_d = word_asm;
                                ram_addr_d  = BASE_ADDR + (word_cnt_ext << 2);
                                word_cnt_d  = cnt_inc;
                                if (cnt_inc == len_q) begin
                                    state_d = ST_FIN;
                                end
                            end
                        end
                    endcase
                end
`ifdef BOOT_CHECKSUM_EN
                ST_CSUM: begin
                    state_d = (bus.rx_rdata == csum_q) ? ST_DONE : ST_ERR;
                end
`endif
                default: ;  // ERR discards drained bytes
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers, synchronous active-low reset
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_LEN;
            byte_idx_q  <= 2'd0;
            shift_q     <= 24'd0;
            len_q       <= '0;
            word_cnt_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= BASE_ADDR;
            ram_wdata_q <= 32'd0;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            shift_q     <= shift_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.rx_re     = take;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;

    assign done_o      = (state_q == ST_DONE);
    assign core_rst_no = (state_q == ST_DONE);
    assign err_o       = (state_q == ST_ERR);
`ifdef BOOT_CHECKSUM_EN
    assign busy_o      = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
`else
    assign busy_o      = (state_q == ST_LEN) || (state_q == ST_DATA);
`endif
    assign words_o     = word_cnt_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_boot_loader
//
// Directed bench for uart_boot_loader. A stream-level model derives every
// expected output from the list of bytes taken since the last reset; a
// negedge checker compares all DUT outputs against it each cycle. Directed
// tests add literal expectations for writes, counts and status flags.
// ---------------------------------------------------------------------------
module tb_uart_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int unsigned MAX  = 1024;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic        acc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] words;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_rst_n;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words;

    uart_boot_loader_if bus ();

    uart_boot_loader #(
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAX),
        .CNT_W     (16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus),
        .core_rst_no (core_rst_n),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .words_o     (words)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          armed    = 1'b0;
    bit          last_took = 1'b0;
    logic [7:0]  rx_log[$];
    logic [63:0] wr_log[$];
    int          wr_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs purely from the byte stream taken since reset.
    function automatic exp_t model();
        exp_t   e;
        longint n;
        longint len;
        longint d;
        longint w;
        e      = '0;
        e.busy = 1'b1;
        e.acc  = 1'b1;
        e.addr = BASE;
        n = longint'(rx_log.size());
        if (n < 4) return e;
        len = longint'({rx_log[3], rx_log[2], rx_log[1], rx_log[0]});
        if (len > longint'(MAX)) begin
            e.busy = 1'b0;
            e.err  = 1'b1;
            return e;
        end
        d = n - 4;
        w = d / 4;
        if (w > len) w = len;
        e.words = 32'(w);
        if (w > 0) begin
            int b;
            b       = 4 + 4 * int'(w - 1);
            e.addr  = BASE + 32'(4 * (w - 1));
            e.wdata = {rx_log[b+3], rx_log[b+2], rx_log[b+1], rx_log[b]};
            e.we    = last_took && (d == 4 * w);
        end
        if (w == len) begin
`ifdef BOOT_CHECKSUM_EN
            logic [7:0] x;
            x = 8'd0;
            for (int i = 0; i < int'(4 + 4 * len); i++) x = x ^ rx_log[i];
            if (n == 4 + 4 * len) return e;
            if (rx_log[int'(4 + 4 * len)] != x) begin
                e.busy = 1'b0;
                e.err  = 1'b1;
                return e;
            end
`endif
            e.busy = 1'b0;
            e.done = 1'b1;
            e.acc  = 1'b0;
        end
        return e;
    endfunction

    // Per-cycle compare, then advance the model by what the next edge takes.
    always @(negedge clk) begin
        exp_t e;
        e = model();
        if (armed) begin
            chk("rx_re",       32'(bus.rx_re),     32'(bus.rx_valid & e.acc));
            chk("ram_we",      32'(bus.ram_we),    32'(e.we));
            chk("ram_addr",    bus.ram_addr,       e.addr);
            chk("ram_wdata",   bus.ram_wdata,      e.wdata);
            chk("core_rst_no", 32'(core_rst_n),    32'(e.done));
            chk("done",        32'(done),          32'(e.done));
            chk("err",         32'(err),           32'(e.err));
            chk("busy",        32'(busy),          32'(e.busy));
            chk("words",       32'(words),         e.words);
            if (bus.ram_we === 1'b1) begin
                wr_log.push_back({bus.ram_addr, bus.ram_wdata});
                wr_cyc.push_back(cyc);
            end
        end
        if (rst_n === 1'b0) begin
            rx_log.delete();
            last_took = 1'b0;
            armed     = 1'b1;
        end else if (armed && bus.rx_valid && e.acc) begin
            rx_log.push_back(bus.rx_rdata);
            last_took = 1'b1;
        end else begin
            last_took = 1'b0;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_log.delete();
        wr_cyc.delete();
    endtask

    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one byte until the DUT takes it (bounded). Called at posedge+1.
    task automatic send_byte(input logic [7:0] b, input bit hold);
        bit ok;
        ok           = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_rdata = b;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.rx_re === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_accept_timeout: byte %h not taken within 50 cycles", b);
        end
        if (!hold) bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit hold);
        send_byte(w[7:0],   1'b1);
        send_byte(w[15:8],  1'b1);
        send_byte(w[23:16], 1'b1);
        send_byte(w[31:24], hold);
    endtask

    function automatic logic [63:0] wr_at(input int i);
        if (i < wr_log.size()) return wr_log[i];
        return 64'hffff_ffff_ffff_ffff;
    endfunction

    logic [63:0] wr;
    int          t_byte;
    int          t_start;
    logic [31:0] t5_data [4];

    initial begin
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_rdata = 8'h00;
        t5_data[0]   = 32'h0302_0100;
        t5_data[1]   = 32'h0706_0504;
        t5_data[2]   = 32'h0B0A_0908;
        t5_data[3]   = 32'h0F0E_0D0C;

        // T1: zero length
        do_reset();
        chk("t1_reset_busy", 32'(busy), 32'd1);
        chk("t1_reset_core", 32'(core_rst_n), 32'd0);
        chk("t1_reset_addr", bus.ram_addr, BASE);
        send_word(32'h0, 1'b0);
        idle(3);
        chk("t1_done",   32'(done), 32'd1);
        chk("t1_core",   32'(core_rst_n), 32'd1);
        chk("t1_words",  32'(words), 32'd0);
        chk("t1_writes", 32'(wr_log.size()), 32'd0);
        bus.rx_valid = 1'b1;
        bus.rx_rdata = 8'hAA;
        #1;
        chk("t1_rx_re_in_done", 32'(bus.rx_re), 32'd0);
        idle(2);

        // T2: two-word image
        do_reset();
        send_word(32'h2, 1'b0);
        send_word(32'h1234_5678, 1'b0);
        t_byte = cyc;
        idle(2);
        send_word(32'hDEAD_BEEF, 1'b0);
        idle(3);
        chk("t2_writes", 32'(wr_log.size()), 32'd2);
        wr = wr_at(0);
        chk("t2_w0_addr", wr[63:32], BASE);
        chk("t2_w0_data", wr[31:0], 32'h1234_5678);
        wr = wr_at(1);
        chk("t2_w1_addr", wr[63:32], BASE + 32'd4);
        chk("t2_w1_data", wr[31:0], 32'hDEAD_BEEF);
        chk("t2_latency", 32'((wr_cyc.size() > 0) ? wr_cyc[0] : -1), 32'(t_byte));
        chk("t2_done",  32'(done), 32'd1);
        chk("t2_words", 32'(words), 32'd2);

        // T3: length MAX+1 aborts and drains
        do_reset();
        send_word(32'h0000_0401, 1'b0);
        idle(2);
        chk("t3_err",    32'(err), 32'd1);
        chk("t3_core",   32'(core_rst_n), 32'd0);
        chk("t3_busy",   32'(busy), 32'd0);
        bus.rx_valid = 1'b1;
        bus.rx_rdata = 8'h55;
        #1;
        chk("t3_drain_re", 32'(bus.rx_re), 32'd1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b0);
        idle(2);
        chk("t3_writes", 32'(wr_log.size()), 32'd0);
        chk("t3_err_held", 32'(err), 32'd1);

        // T4: reset mid-load, then a one-word image
        do_reset();
        send_word(32'h3, 1'b0);
        send_word(32'hA1A2_A3A4, 1'b0);
        send_byte(8'hB1, 1'b0);
        do_reset();
        chk("t4_mid_busy",  32'(busy), 32'd1);
        chk("t4_mid_core",  32'(core_rst_n), 32'd0);
        chk("t4_mid_words", 32'(words), 32'd0);
        send_word(32'h1, 1'b0);
        send_word(32'h1122_3344, 1'b0);
        idle(3);
        chk("t4_writes", 32'(wr_log.size()), 32'd1);
        wr = wr_at(0);
        chk("t4_w0_addr", wr[63:32], BASE);
        chk("t4_w0_data", wr[31:0], 32'h1122_3344);
        chk("t4_done",  32'(done), 32'd1);
        chk("t4_words", 32'(words), 32'd1);

        // T5: back-to-back stream, one byte per cycle
        do_reset();
        t_start = cyc;
        send_word(32'h4, 1'b1);
        for (int i = 0; i < 4; i++) send_word(t5_data[i], i != 3);
        chk("t5_cycles", 32'(cyc - t_start), 32'd20);
        idle(3);
        chk("t5_writes", 32'(wr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            wr = wr_at(i);
            chk("t5_addr", wr[63:32], BASE + 32'(4 * i));
            chk("t5_data", wr[31:0], t5_data[i]);
        end
        chk("t5_done",  32'(done), 32'd1);
        chk("t5_words", 32'(words), 32'd4);

`ifdef BOOT_CHECKSUM_EN
        // T6: XOR of 02 00 00 00 78 56 34 12 EF BE AD DE is 0x28
        do_reset();
        send_word(32'h2, 1'b0);
        send_word(32'h1234_5678, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        idle(1);
        chk("t6_wait_busy", 32'(busy), 32'd1);
        send_byte(8'h28, 1'b0);
        idle(2);
        chk("t6_good_done", 32'(done), 32'd1);
        chk("t6_good_writes", 32'(wr_log.size()), 32'd2);
        do_reset();
        send_word(32'h2, 1'b0);
        send_word(32'h1234_5678, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        send_byte(8'h29, 1'b0);
        idle(2);
        chk("t6_bad_err",  32'(err), 32'd1);
        chk("t6_bad_core", 32'(core_rst_n), 32'd0);
`endif

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
